ultrasonic_array_ctrl: RTL and testbench

- Multi-channel HC-SR04 scan controller: pings N_CH sensors round-robin, one at a time.
- Measures echo width in clk cycles with timeout and inter-ping guard gap.
- Keeps a debounced, hysteretic occupancy flag per bay and emits per-channel entry/exit pulses to the parking FSM.
- Sits between the sensor pins and the parking FSM; replaces per-sensor single-shot controllers.

---
 rtl/ultrasonic_array_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_ultrasonic_array_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ultrasonic_array_ctrl.sv
// ultrasonic_array_ctrl: round-robin scan controller for N_CH HC-SR04 sensors.
// Pings one sensor at a time, measures echo width in clk cycles (with a
// timeout and an inter-ping guard gap), and keeps a debounced, hysteretic
// occupancy flag per bay with one-cycle entry/exit pulses.
// Optional build macro: US_TIMEOUT_STATS_EN adds timeout_cnt and stuck outputs.
module ultrasonic_array_ctrl #(
  parameter int N_CH           = 4,
  parameter int CNT_W          = 22,
  parameter int TRIG_CYCLES    = 400,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int GAP_CYCLES     = 2400000,
  parameter int ENTRY_TH       = 11664,
  parameter int EXIT_TH        = 23328,
  parameter int DEB            = 3,
  localparam int CH_W          = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [N_CH-1:0]  echo,
  output logic [N_CH-1:0]  trig,
  output logic             busy,
  output logic             dist_valid,
  output logic [CH_W-1:0]  dist_ch,
  output logic [CNT_W-1:0] dist_raw,
  output logic             dist_timeout,
  output logic [N_CH-1:0]  occupied,
  output logic [N_CH-1:0]  car_entry,
  output logic [N_CH-1:0]  car_exit
`ifdef US_TIMEOUT_STATS_EN
  ,
  output logic [15:0]      timeout_cnt,
  output logic [N_CH-1:0]  stuck
`endif
);

  localparam int PH_MAX = (TRIG_CYCLES > GAP_CYCLES) ? TRIG_CYCLES : GAP_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int DEB_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE, S_TRIGGER, S_WAIT_ECHO, S_COUNT, S_DONE, S_GAP
  } state_t;

  state_t            state, next_state;
  logic [CH_W-1:0]   ch;
  logic [PH_W-1:0]   ph_cnt;
  logic [TMO_W-1:0]  tmo_cnt;
  logic [CNT_W-1:0]  width;
  logic [N_CH-1:0]   echo_meta, echo_sync;
  logic              echo_s;
  logic              trig_last, gap_last, tmo_hit;

  logic [DEB_W-1:0]  near_cnt [N_CH];
  logic [DEB_W-1:0]  far_cnt  [N_CH];
  logic [DEB_W-1:0]  near_nxt, far_nxt;
  logic              sample_near, sample_far;

  assign echo_s    = echo_sync[ch];
  assign trig_last = (ph_cnt == PH_W'(TRIG_CYCLES - 1));
  assign gap_last  = (ph_cnt == PH_W'(GAP_CYCLES - 1));
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  // Two-flop synchroniser on every raw echo input.
  // NOTE: non-blocking assignments so each flop samples the pre-edge value of its source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_meta <= '0;
      echo_sync <= '0;
    end else begin
      echo_meta <= echo;
      echo_sync <= echo_meta;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // FSM next-state logic; timeout wins over an echo edge in the same cycle.
  // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:      if (enable) next_state = S_TRIGGER;
      S_TRIGGER:   if (trig_last) next_state = S_WAIT_ECHO;
      S_WAIT_ECHO: if (tmo_hit) next_state = S_DONE;
                   else if (echo_s) next_state = S_COUNT;
      S_COUNT:     if (tmo_hit || !echo_s) next_state = S_DONE;
      S_DONE:      next_state = S_GAP;
      S_GAP:       if (gap_last) next_state = enable ? S_TRIGGER : S_IDLE;
      default:     next_state = S_IDLE;
    endcase
  end

  // FSM outputs decoded from the state register; reset drops trig at once.
  always_comb begin
    trig       = '0;
    busy       = (state != S_IDLE);
    dist_valid = (state == S_DONE);
    if (state == S_TRIGGER) trig[ch] = 1'b1;
  end

  // Phase (trigger/gap), timeout and echo-width counters plus channel pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ph_cnt  <= '0;
      tmo_cnt <= '0;
      width   <= '0;
      ch      <= '0;
    end else begin
      if (next_state != state)
        ph_cnt <= '0;
      else if (state == S_TRIGGER || state == S_GAP)
        ph_cnt <= ph_cnt + 1'b1;

      if (state == S_TRIGGER)
        tmo_cnt <= '0;
      else if (state == S_WAIT_ECHO || state == S_COUNT)
        tmo_cnt <= tmo_cnt + 1'b1;

      if (state == S_TRIGGER)
        width <= '0;
      else if (state == S_WAIT_ECHO && echo_s)
        width <= CNT_W'(1);
      else if (state == S_COUNT && echo_s && !(&width))
        width <= width + 1'b1;

      if (state == S_GAP && gap_last)
        ch <= (ch == CH_W'(N_CH - 1)) ? '0 : ch + 1'b1;
    end
  end

  // Capture the measurement result on entry to DONE; held until the next DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dist_ch      <= '0;
      dist_raw     <= '0;
      dist_timeout <= 1'b0;
    end else if ((state == S_WAIT_ECHO || state == S_COUNT) && next_state == S_DONE) begin
      dist_ch      <= ch;
      dist_timeout <= tmo_hit;
      dist_raw     <= tmo_hit ? '0 : width;
    end
  end

  // Classify the finished sample and compute saturating debounce counts.
  always_comb begin
    sample_near = !dist_timeout && (dist_raw < CNT_W'(ENTRY_TH));
    sample_far  = dist_timeout || (dist_raw > CNT_W'(EXIT_TH));
    near_nxt    = '0;
    far_nxt     = '0;
    if (sample_near)
      near_nxt = (near_cnt[dist_ch] >= DEB_W'(DEB)) ? DEB_W'(DEB) : near_cnt[dist_ch] + 1'b1;
    if (sample_far)
      far_nxt = (far_cnt[dist_ch] >= DEB_W'(DEB)) ? DEB_W'(DEB) : far_cnt[dist_ch] + 1'b1;
  end

  // Per-channel debounce and occupancy; only the measured channel updates.
  // NOTE: the counter arrays are reset explicitly because occupancy must start clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occupied  <= '0;
      car_entry <= '0;
      car_exit  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        near_cnt[i] <= '0;
        far_cnt[i]  <= '0;
      end
    end else begin
      car_entry <= '0;
      car_exit  <= '0;
      if (state == S_DONE) begin
        near_cnt[dist_ch] <= near_nxt;
        far_cnt[dist_ch]  <= far_nxt;
        if (near_nxt == DEB_W'(DEB) && !occupied[dist_ch]) begin
          occupied[dist_ch]  <= 1'b1;
          car_entry[dist_ch] <= 1'b1;
        end
        if (far_nxt == DEB_W'(DEB) && occupied[dist_ch]) begin
          occupied[dist_ch] <= 1'b0;
          car_exit[dist_ch] <= 1'b1;
        end
      end
    end
  end

`ifdef US_TIMEOUT_STATS_EN
  logic [2:0] tmo_run [N_CH];

  // Global timeout counter and per-channel stuck detection (4 timeouts in a row).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeout_cnt <= '0;
      stuck       <= '0;
      for (int i = 0; i < N_CH; i++) tmo_run[i] <= '0;
    end else if (state == S_DONE) begin
      if (dist_timeout) begin
        if (timeout_cnt != 16'hFFFF) timeout_cnt <= timeout_cnt + 1'b1;
        if (tmo_run[dist_ch] != 3'd4) tmo_run[dist_ch] <= tmo_run[dist_ch] + 1'b1;
        if (tmo_run[dist_ch] >= 3'd3) stuck[dist_ch] <= 1'b1;
      end else begin
        tmo_run[dist_ch] <= '0;
        stuck[dist_ch]   <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ultrasonic_array_ctrl.sv
// Directed bench for ultrasonic_array_ctrl: scan order, trigger length,
// echo width, timeout, entry/exit debounce with hysteresis, and mid-ping reset.
module tb_ultrasonic_array_ctrl;

  localparam int N_CH      = 2;
  localparam int CNT_W     = 22;
  localparam int TRIG      = 4;
  localparam int TMO       = 200;
  localparam int GAP       = 10;
  localparam int DEB       = 2;
  localparam int ENTRY     = 20;
  localparam int EXIT      = 50;
  localparam int IDLE_ECHO = -1;  // echo never rises: timeout
  localparam int HOLD_ECHO = -2;  // echo held high through the ping: timeout

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             enable = 1'b0;
  logic [N_CH-1:0]  echo = '0;
  logic [N_CH-1:0]  trig;
  logic             busy;
  logic             dist_valid;
  logic [0:0]       dist_ch;
  logic [CNT_W-1:0] dist_raw;
  logic             dist_timeout;
  logic [N_CH-1:0]  occupied;
  logic [N_CH-1:0]  car_entry;
  logic [N_CH-1:0]  car_exit;

  typedef struct {
    int               ch;
    logic [CNT_W-1:0] raw;
    logic             to;
    logic [N_CH-1:0]  occ;
    logic [N_CH-1:0]  ent;
    logic [N_CH-1:0]  ext;
  } exp_t;

  exp_t sb[$];
  int   passed = 0;
  int   total  = 0;
  logic multi_trig = 1'b0;

  ultrasonic_array_ctrl #(
    .N_CH(N_CH), .CNT_W(CNT_W), .TRIG_CYCLES(TRIG), .TIMEOUT_CYCLES(TMO),
    .GAP_CYCLES(GAP), .ENTRY_TH(ENTRY), .EXIT_TH(EXIT), .DEB(DEB)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .echo(echo), .trig(trig),
    .busy(busy), .dist_valid(dist_valid), .dist_ch(dist_ch),
    .dist_raw(dist_raw), .dist_timeout(dist_timeout), .occupied(occupied),
    .car_entry(car_entry), .car_exit(car_exit)
  );

  always #5 clk = ~clk;

  // More than one trigger bit high at once is never allowed.
  always @(negedge clk) if ($countones(trig) > 1) multi_trig <= 1'b1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic finish_run();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  endtask

  // One ping on channel ch. width > 0: echo pulse of that many cycles after
  // the trigger; IDLE_ECHO / HOLD_ECHO: timed-out measurement.
  task automatic ping(input int ch, input int width, input logic [N_CH-1:0] occ_e,
                      input logic [N_CH-1:0] ent_e, input logic [N_CH-1:0] ext_e);
    exp_t e;
    exp_t got;
    int   n;
    logic wrong;
    e.ch  = ch;
    e.to  = (width < 0);
    e.raw = (width < 0) ? '0 : CNT_W'(width);
    e.occ = occ_e;
    e.ent = ent_e;
    e.ext = ext_e;
    sb.push_back(e);
    if (width == HOLD_ECHO) echo[ch] = 1'b1;

    n = 0;
    wrong = 1'b0;
    while (!trig[ch] && n < 100) begin
      if (trig != '0) wrong = 1'b1;
      @(negedge clk);
      n++;
    end
    if (!trig[ch]) begin
      check($sformatf("trig_wait_ch%0d", ch), 32'd0, 32'd1);
      finish_run();
    end
    check($sformatf("trig_order_ch%0d", ch), 32'(wrong), 32'd0);

    n = 0;
    while (trig[ch] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("trig_len_ch%0d", ch), 32'(n), 32'(TRIG));

    if (width > 0) begin
      echo[ch] = 1'b1;
      repeat (width) @(negedge clk);
      echo[ch] = 1'b0;
    end

    n = 0;
    while (!dist_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (!dist_valid || sb.size() == 0) begin
      check($sformatf("dist_valid_wait_ch%0d", ch), 32'd0, 32'd1);
      finish_run();
    end
    got = sb.pop_front();
    check("dist_ch", 32'(dist_ch), 32'(got.ch));
    check("dist_raw", 32'(dist_raw), 32'(got.raw));
    check("dist_timeout", 32'(dist_timeout), 32'(got.to));

    @(negedge clk);
    check("car_entry", 32'(car_entry), 32'(got.ent));
    check("car_exit", 32'(car_exit), 32'(got.ext));
    check("occupied", 32'(occupied), 32'(got.occ));
    if (width == HOLD_ECHO) echo[ch] = 1'b0;

    @(negedge clk);
    check("pulse_single_cycle", 32'({car_entry, car_exit}), 32'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    enable = 1'b0;
    echo = '0;
    repeat (3) @(negedge clk);
    check("rst_trig", 32'(trig), 32'd0);
    check("rst_busy_valid", 32'({busy, dist_valid}), 32'd0);
    check("rst_dist", 32'({dist_ch, dist_timeout, dist_raw}), 32'd0);
    check("rst_occ", 32'({occupied, car_entry, car_exit}), 32'd0);

    rst = 1'b0;
    @(negedge clk);
    enable = 1'b1;

    // Scan order and timeouts with idle echo.
    ping(0, IDLE_ECHO, 2'b00, 2'b00, 2'b00);
    ping(1, IDLE_ECHO, 2'b00, 2'b00, 2'b00);
    // Echo width measurement.
    ping(0, 15,        2'b00, 2'b00, 2'b00);
    ping(1, IDLE_ECHO, 2'b00, 2'b00, 2'b00);
    ping(0, IDLE_ECHO, 2'b00, 2'b00, 2'b00);
    ping(1, IDLE_ECHO, 2'b00, 2'b00, 2'b00);
    // Entry debounce on ch0.
    ping(0, 10,        2'b00, 2'b00, 2'b00);
    ping(1, IDLE_ECHO, 2'b00, 2'b00, 2'b00);
    ping(0, 10,        2'b01, 2'b01, 2'b00);
    ping(1, IDLE_ECHO, 2'b01, 2'b00, 2'b00);
    ping(0, 10,        2'b01, 2'b00, 2'b00);
    // Hysteresis on ch0 (30, 60, 30, 60, 60) interleaved with ch1 entry/exit.
    ping(1, 10,        2'b01, 2'b00, 2'b00);
    ping(0, 30,        2'b01, 2'b00, 2'b00);
    ping(1, 10,        2'b11, 2'b10, 2'b00);
    ping(0, 60,        2'b11, 2'b00, 2'b00);
    ping(1, HOLD_ECHO, 2'b11, 2'b00, 2'b00);
    ping(0, 30,        2'b11, 2'b00, 2'b00);
    ping(1, HOLD_ECHO, 2'b01, 2'b00, 2'b10);
    ping(0, 60,        2'b01, 2'b00, 2'b00);
    ping(1, IDLE_ECHO, 2'b01, 2'b00, 2'b00);
    ping(0, 60,        2'b00, 2'b00, 2'b01);
    // Re-occupy ch1 and leave ch0 with a partial near count before reset.
    ping(1, 10,        2'b00, 2'b00, 2'b00);
    ping(0, 10,        2'b00, 2'b00, 2'b00);
    ping(1, 10,        2'b10, 2'b10, 2'b00);

    // Reset in the middle of the next ch0 trigger pulse.
    n = 0;
    while (!trig[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("reset_test_trig_seen", 32'(trig[0]), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midping_rst_trig", 32'(trig), 32'd0);
    check("midping_rst_busy_valid", 32'({busy, dist_valid}), 32'd0);
    check("midping_rst_dist", 32'({dist_ch, dist_timeout, dist_raw}), 32'd0);
    check("midping_rst_occ", 32'({occupied, car_entry, car_exit}), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Scan restarts at ch0 with cleared debounce counters: one near sample each
    // must not produce an entry.
    ping(0, 10, 2'b00, 2'b00, 2'b00);
    ping(1, 10, 2'b00, 2'b00, 2'b00);

    check("trig_onehot", 32'(multi_trig), 32'd0);
    finish_run();
  end

endmodule
